// File: rtl/vga_pkg.sv
// Shared video timing package: 640x480@60 constants, colour depth and coordinate types.
package vga_pkg;

    localparam int unsigned CD = 12;

    localparam int unsigned HD = 640;
    localparam int unsigned HF = 16;
    localparam int unsigned HR = 96;
    localparam int unsigned HB = 48;
    localparam int unsigned HT = HD + HF + HR + HB;

    localparam int unsigned VD = 480;
    localparam int unsigned VF = 10;
    localparam int unsigned VR = 2;
    localparam int unsigned VB = 33;
    localparam int unsigned VT = VD + VF + VR + VB;

    typedef logic [10:0]   coord_t;
    typedef logic [CD-1:0] rgb_t;

    // Inclusive range test used by the sync decoders.
    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_frame_core_if.sv
// Video timing bundle between the frame core and the sprite/overlay pipeline.
interface vga_sync_frame_core_if #(
    parameter int unsigned CD = vga_pkg::CD
);
    import vga_pkg::*;

    coord_t          x;
    coord_t          y;
    logic            pixel_tick;
    logic            frame_start;
    logic [31:0]     frame_cnt;
    logic [CD-1:0]   si_rgb;
    logic            hsync;
    logic            vsync;
    logic [CD-1:0]   rgb;

    // Timing generator side.
    modport master (
        output x, y, pixel_tick, frame_start, frame_cnt, hsync, vsync, rgb,
        input  si_rgb
    );

    // Pipeline / consumer side.
    modport slave (
        input  x, y, pixel_tick, frame_start, frame_cnt, hsync, vsync, rgb,
        output si_rgb
    );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that advances every clk; reset loads every stage with INIT.
module sync_delay_line #(
    parameter int unsigned     WIDTH = 3,
    parameter int unsigned     DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per clk; reset parks every stage at the inactive value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= INIT;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_frame_core.sv
// VGA timing head: pixel divider, x/y frame counters, frame pulse/count, sync decode,
// sync/video_on re-timing to the sprite pipeline latency and final RGB blanking.
module vga_sync_frame_core
    import vga_pkg::*;
#(
    parameter int unsigned CD       = vga_pkg::CD,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned HD       = vga_pkg::HD,
    parameter int unsigned HF       = vga_pkg::HF,
    parameter int unsigned HR       = vga_pkg::HR,
    parameter int unsigned HB       = vga_pkg::HB,
    parameter int unsigned VD       = vga_pkg::VD,
    parameter int unsigned VF       = vga_pkg::VF,
    parameter int unsigned VR       = vga_pkg::VR,
    parameter int unsigned VB       = vga_pkg::VB,
    parameter int unsigned SYNC_DLY = 2  // 1..15
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_sync_frame_core_if.master io_vga
);

    localparam int unsigned L_HT = HD + HF + HR + HB;
    localparam int unsigned L_VT = VD + VF + VR + VB;
    localparam int unsigned L_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [L_DW-1:0] L_DIV_MAX = L_DW'(CLK_DIV - 1);
    localparam coord_t L_HT_M1   = coord_t'(L_HT - 1);
    localparam coord_t L_VT_M1   = coord_t'(L_VT - 1);
    localparam coord_t L_HD      = coord_t'(HD);
    localparam coord_t L_VD      = coord_t'(VD);
    localparam coord_t L_HS_BEG  = coord_t'(HD + HF);
    localparam coord_t L_HS_END  = coord_t'(HD + HF + HR - 1);
    localparam coord_t L_VS_BEG  = coord_t'(VD + VF);
    localparam coord_t L_VS_END  = coord_t'(VD + VF + VR - 1);

    logic [L_DW-1:0] r_div;
    logic            r_tick;
    coord_t          r_x;
    coord_t          r_y;
    logic            r_frame_start;
    logic [31:0]     r_frame_cnt;
    logic            r_hsync;
    logic            r_vsync;
    logic [CD-1:0]   r_rgb;

    logic [L_DW-1:0] w_div_nxt;
    logic            w_x_wrap;
    logic            w_y_wrap;
    logic            w_frame_wrap;
    logic            w_hs_raw;
    logic            w_vs_raw;
    logic            w_von_raw;
    logic [2:0]      w_dly_out;

    assign w_div_nxt    = (r_div == L_DIV_MAX) ? '0 : r_div + 1'b1;
    assign w_x_wrap     = (r_x == L_HT_M1);
    assign w_y_wrap     = (r_y == L_VT_M1);
    assign w_frame_wrap = r_tick & w_x_wrap & w_y_wrap;

    // Pixel divider; the tick is registered so it is high exactly while r_div == CLK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_tick <= (w_div_nxt == L_DIV_MAX);
        end
    end

    // Frame position: x advances per tick, y advances on the tick where x wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_tick) begin
            r_x <= w_x_wrap ? '0 : r_x + 1'b1;
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? '0 : r_y + 1'b1;
            end
        end
    end

    // Frame pulse lands with (0,0) itself; the (0,0) entered by reset produces no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

    // Raw sync/active-video decode from the current position.
    always_comb begin
        w_hs_raw  = !in_span(r_x, L_HS_BEG, L_HS_END);
        w_vs_raw  = !in_span(r_y, L_VS_BEG, L_VS_END);
        w_von_raw = (r_x < L_HD) && (r_y < L_VD);
    end

    // Match the sprite-stage latency; idle stages hold syncs high and video off.
    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (SYNC_DLY),
        .INIT  (3'b110)
    ) u_sync_delay_line (
        .clk   (clk),
        .reset (reset),
        .i_d   ({w_hs_raw, w_vs_raw, w_von_raw}),
        .o_q   (w_dly_out)
    );

    // Pin register: delayed syncs plus RGB blanked by the delayed video_on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_dly_out[2];
            r_vsync <= w_dly_out[1];
            r_rgb   <= w_dly_out[0] ? io_vga.si_rgb : '0;
        end
    end

    assign io_vga.x           = r_x;
    assign io_vga.y           = r_y;
    assign io_vga.pixel_tick  = r_tick;
    assign io_vga.frame_start = r_frame_start;
    assign io_vga.frame_cnt   = r_frame_cnt;
    assign io_vga.hsync       = r_hsync;
    assign io_vga.vsync       = r_vsync;
    assign io_vga.rgb         = r_rgb;

endmodule

// File: tb/tb_vga_sync_frame_core.sv
// Scoreboard bench for vga_sync_frame_core: two instances on a reduced raster
// (CLK_DIV=4/SYNC_DLY=2 and CLK_DIV=1/SYNC_DLY=1), checked every clk against an
// arithmetic model driven by the number of clk edges since reset release.
module tb_vga_sync_frame_core;

    localparam int unsigned CD = 12;
    localparam int unsigned HD = 20, HF = 4, HR = 6, HB = 5;
    localparam int unsigned VD = 10, VF = 2, VR = 2, VB = 3;
    localparam int unsigned HT = HD + HF + HR + HB;
    localparam int unsigned VT = VD + VF + VR + VB;
    localparam int unsigned FR = HT * VT;
    localparam int unsigned NI = 2;
    localparam int unsigned CDIV_A = 4, DLY_A = 2;
    localparam int unsigned CDIV_B = 1, DLY_B = 1;

    typedef struct packed {
        logic [10:0]   x;
        logic [10:0]   y;
        logic          tick;
        logic          fs;
        logic [31:0]   fc;
        logic          hs;
        logic          vs;
        logic [CD-1:0] rgb;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [CD-1:0] si_rgb;
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   n_cyc [NI];
    obs_t          exp_q [NI][$];
    obs_t          act   [NI];

    always #5 clk = ~clk;

    vga_sync_frame_core_if #(.CD(CD)) vga_a ();
    vga_sync_frame_core_if #(.CD(CD)) vga_b ();

    assign vga_a.si_rgb = si_rgb;
    assign vga_b.si_rgb = si_rgb;

    vga_sync_frame_core #(
        .CD(CD), .CLK_DIV(CDIV_A), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB), .SYNC_DLY(DLY_A)
    ) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .io_vga (vga_a)
    );

    vga_sync_frame_core #(
        .CD(CD), .CLK_DIV(CDIV_B), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB), .SYNC_DLY(DLY_B)
    ) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .io_vga (vga_b)
    );

    assign act[0] = {vga_a.x, vga_a.y, vga_a.pixel_tick, vga_a.frame_start, vga_a.frame_cnt,
                     vga_a.hsync, vga_a.vsync, vga_a.rgb};
    assign act[1] = {vga_b.x, vga_b.y, vga_b.pixel_tick, vga_b.frame_start, vga_b.frame_cnt,
                     vga_b.hsync, vga_b.vsync, vga_b.rgb};

    function automatic int unsigned cdiv_of(int unsigned i);
        return (i == 0) ? CDIV_A : CDIV_B;
    endfunction

    function automatic int unsigned dly_of(int unsigned i);
        return (i == 0) ? DLY_A : DLY_B;
    endfunction

    // Pixel ticks consumed by the first n edges after reset release.
    // With CLK_DIV=1 the tick is high from the first edge onward.
    function automatic int unsigned ticks_at(int unsigned n, int unsigned cdiv);
        if (cdiv == 1) return (n == 0) ? 0 : n - 1;
        return n / cdiv;
    endfunction

    // {hs, vs, von} decoded from the raster position after edge m.
    function automatic logic [2:0] raw_at(int unsigned m, int unsigned cdiv);
        int unsigned p;
        int unsigned xx;
        int unsigned yy;
        logic [2:0]  r;
        p  = ticks_at(m, cdiv) % FR;
        xx = p % HT;
        yy = p / HT;
        r[2] = !((xx >= HD + HF) && (xx < HD + HF + HR));
        r[1] = !((yy >= VD + VF) && (yy < VD + VF + VR));
        r[0] = (xx < HD) && (yy < VD);
        return r;
    endfunction

    // Expected outputs in the clk following edge n (n=0: reset / before the first edge).
    function automatic obs_t expect_at(int unsigned n, int unsigned cdiv, int unsigned dly,
                                       logic [CD-1:0] si);
        obs_t        e;
        int unsigned t;
        int unsigned p;
        logic [2:0]  r;
        t      = ticks_at(n, cdiv);
        p      = t % FR;
        e.x    = 11'(p % HT);
        e.y    = 11'(p / HT);
        e.tick = (n >= 1) && ((n % cdiv) == cdiv - 1);
        e.fc   = t / FR;
        e.fs   = (n >= 1) && (t != ticks_at(n - 1, cdiv)) && (p == 0);
        r      = (n >= dly + 1) ? raw_at(n - dly - 1, cdiv) : 3'b110;
        e.hs   = r[2];
        e.vs   = r[1];
        e.rgb  = r[0] ? si : '0;
        return e;
    endfunction

    task automatic check(string what, int unsigned idx, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d n=%0d t=%0t: got %0h, want %0h",
                     what, idx, n_cyc[idx], $time, got, want);
        end
    endtask

    task automatic check_obs(int unsigned idx, obs_t a, obs_t e);
        check("x",           idx, 32'(a.x),    32'(e.x));
        check("y",           idx, 32'(a.y),    32'(e.y));
        check("pixel_tick",  idx, 32'(a.tick), 32'(e.tick));
        check("frame_start", idx, 32'(a.fs),   32'(e.fs));
        check("frame_cnt",   idx, a.fc,        e.fc);
        check("hsync",       idx, 32'(a.hs),   32'(e.hs));
        check("vsync",       idx, 32'(a.vs),   32'(e.vs));
        check("rgb",         idx, 32'(a.rgb),  32'(e.rgb));
    endtask

    // Reference side: after each edge, push what the DUTs must show until the next edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < int'(NI); i++) begin
            if (reset) n_cyc[i] = 0;
            else       n_cyc[i] = n_cyc[i] + 1;
            exp_q[i].push_back(expect_at(n_cyc[i], cdiv_of(i), dly_of(i), si_rgb));
        end
    end

    // Monitor: outputs are stable mid-cycle, pop and compare.
    always @(negedge clk) begin
        for (int i = 0; i < int'(NI); i++) begin
            if (exp_q[i].size() != 0) begin
                check_obs(i, act[i], exp_q[i].pop_front());
            end
        end
    end

    initial begin
        reset  = 1'b1;
        si_rgb = 12'hF0F;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Constant colour across more than one full frame of the slower instance.
        repeat (3000) @(negedge clk);

        repeat (400) begin
            @(negedge clk);
            si_rgb = CD'($urandom);
        end

        // Asynchronous reset mid-frame: outputs must clear without waiting for an edge.
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < int'(NI); i++) begin
            check_obs(i, act[i], expect_at(0, cdiv_of(i), dly_of(i), si_rgb));
        end
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        repeat (3000) begin
            @(negedge clk);
            si_rgb = CD'($urandom);
        end
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
